// File: rtl/smi_frame_arbiter_x4.sv
// ---------------------------------------------------------------------------
// smi_frame_arbiter_x4
//
// Purpose:
//   Merges four SMI input streams (A..D) onto a single SMI output at frame
//   granularity. Arbitration is round-robin. Once an input is granted, it owns
//   the output until the flit carrying a nonzero Eofc transfers, so frames are
//   never interleaved. The output is one register stage deep.
//
// Handshake (input and output sides alike):
//   A flit moves on a cycle where Ready=1 and Stop=0. The sender holds
//   Ready/Eofc/Data stable while Stop=1. A nonzero Eofc marks the last flit
//   of a frame.
//
// Ports:
//   clk, rstn                          clock and async active-low reset
//   smiIn{A..D}Ready/Eofc/Data (in)    input flit valid, end-of-frame, data
//   smiIn{A..D}Stop            (out)   input backpressure
//   smiOutReady/Eofc/Data      (out)   registered output flit
//   smiOutStop                 (in)    output backpressure
//   smiFrameCnt{A..D}          (out)   completed-frame counters, saturating
//                                      (only when SMI_ARB_STATS_EN is defined)
//
// Build option:
//   SMI_ARB_STATS_EN - adds the per-input completed-frame counters. The
//   arbitration behaviour is the same with and without it.
// ---------------------------------------------------------------------------
module smi_frame_arbiter_x4 #(
    parameter int FlitWidth = 16,
    parameter int CntWidth  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,
    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,
    input  logic                   smiInCReady,
    input  logic [7:0]             smiInCEofc,
    input  logic [FlitWidth*8-1:0] smiInCData,
    output logic                   smiInCStop,
    input  logic                   smiInDReady,
    input  logic [7:0]             smiInDEofc,
    input  logic [FlitWidth*8-1:0] smiInDData,
    output logic                   smiInDStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
`ifdef SMI_ARB_STATS_EN
    ,
    output logic [CntWidth-1:0]    smiFrameCntA,
    output logic [CntWidth-1:0]    smiFrameCntB,
    output logic [CntWidth-1:0]    smiFrameCntC,
    output logic [CntWidth-1:0]    smiFrameCntD
`endif
);

    localparam int DW = FlitWidth * 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Complete arbiter state in one struct so checkers can bind to it.
    typedef struct packed {
        state_e     state;
        logic [1:0] grant;
        logic [1:0] ptr;    // last served input; lowest priority next scan
    } arb_state_t;

    arb_state_t arb_q;

    logic [3:0]    in_ready;
    logic [7:0]    in_eofc [4];
    logic [DW-1:0] in_data [4];
    logic [3:0]    in_stop_d;

    logic          out_ready_q;
    logic [7:0]    out_eofc_q;
    logic [DW-1:0] out_data_q;

    logic          load_en;
    logic          accept;
    logic          last_xfer;
    logic          scan_hit_d;
    logic [1:0]    scan_idx_d;

    assign in_ready = {smiInDReady, smiInCReady, smiInBReady, smiInAReady};
    assign in_eofc[0] = smiInAEofc;
    assign in_eofc[1] = smiInBEofc;
    assign in_eofc[2] = smiInCEofc;
    assign in_eofc[3] = smiInDEofc;
    assign in_data[0] = smiInAData;
    assign in_data[1] = smiInBData;
    assign in_data[2] = smiInCData;
    assign in_data[3] = smiInDData;

    // The output register can take a new value unless it holds a flit that
    // the downstream side is currently refusing.
    assign load_en   = ~(out_ready_q & smiOutStop);
    assign accept    = (arb_q.state == ACTIVE) & in_ready[arb_q.grant] & load_en;
    assign last_xfer = accept & (in_eofc[arb_q.grant] != 8'h00);

    // Only the granted input ever sees Stop low, and only while the output
    // register can load; every other input is held off without losing data.
    always_comb begin
        in_stop_d = 4'hF;
        if (arb_q.state == ACTIVE) begin
            in_stop_d[arb_q.grant] = ~load_en;
        end
    end

    assign smiInAStop = in_stop_d[0];
    assign smiInBStop = in_stop_d[1];
    assign smiInCStop = in_stop_d[2];
    assign smiInDStop = in_stop_d[3];

    // Rotating scan: ptr+1, ptr+2, ptr+3, then ptr itself last.
    always_comb begin
        logic [1:0] cand;
        scan_hit_d = 1'b0;
        scan_idx_d = arb_q.ptr;
        cand       = arb_q.ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = arb_q.ptr + 2'(i);
            if (!scan_hit_d && in_ready[cand]) begin
                scan_hit_d = 1'b1;
                scan_idx_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arb_q.state <= IDLE;
            arb_q.grant <= 2'd0;
            arb_q.ptr   <= 2'd3;    // D was "last served", so A wins first
        end else begin
            case (arb_q.state)
                IDLE: begin
                    if (scan_hit_d) begin
                        arb_q.grant <= scan_idx_d;
                        arb_q.state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (last_xfer) begin
                        arb_q.ptr   <= arb_q.grant;
                        arb_q.state <= IDLE;
                    end
                end
                default: arb_q.state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_ready_q <= 1'b0;
            out_eofc_q  <= 8'h00;
            out_data_q  <= '0;
        end else if (load_en) begin
            out_ready_q <= accept;
            if (accept) begin
                out_eofc_q <= in_eofc[arb_q.grant];
                out_data_q <= in_data[arb_q.grant];
            end
        end
    end

    assign smiOutReady = out_ready_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutData  = out_data_q;

`ifdef SMI_ARB_STATS_EN
    logic [CntWidth-1:0] cnt_q [4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (last_xfer && (cnt_q[arb_q.grant] != {CntWidth{1'b1}})) begin
            cnt_q[arb_q.grant] <= cnt_q[arb_q.grant] + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign smiFrameCntA = cnt_q[0];
    assign smiFrameCntB = cnt_q[1];
    assign smiFrameCntC = cnt_q[2];
    assign smiFrameCntD = cnt_q[3];
`endif

endmodule
